// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } led_mode_e;

  // A zero half-period would never reach its terminal count, so treat it as one tick.
  function automatic logic [31:0] clamp_half(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: holds its mode and blink/PWM settings and registers its LED bit.
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int                 PER_W      = 16,
  parameter int                 DUTY_W     = 4,
  parameter led_mode_e          BOOT_MODE  = MODE_OFF,
  parameter logic [PER_W-1:0]   BOOT_HALF  = PER_W'(1),
  parameter logic               BOOT_PHASE = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic              wr_en,
  input  led_mode_e         wr_mode,
  input  logic [PER_W-1:0]  wr_half,
  input  logic [DUTY_W-1:0] wr_duty,
  output logic              led
);

  led_mode_e         mode_q, mode_d;
  logic [PER_W-1:0]  half_q, half_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [PER_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              led_q, led_d;

  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // A write takes priority, so a tick landing on the same edge is dropped.
    if (wr_en) begin
      mode_d  = wr_mode;
      half_d  = PER_W'(clamp_half(32'(wr_half)));
      duty_d  = wr_duty;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (cnt_q == half_q - PER_W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end

    led_d = 1'b0;
    unique case (mode_q)
      MODE_OFF:   led_d = 1'b0;
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = phase_q;
      MODE_PWM:   led_d = (pwm_cnt < duty_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= BOOT_MODE;
      half_q  <= BOOT_HALF;
      duty_q  <= '0;
      cnt_q   <= '0;
      phase_q <= BOOT_PHASE;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_bank.sv
// Multi-channel LED driver: shared tick prescaler and PWM base counter feeding N_CH channels.
module led_blink_bank
  import led_blink_pkg::*;
#(
  parameter int CLK_HZ         = 12_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int N_CH           = 4,
  parameter int PER_W          = 16,
  parameter int DUTY_W         = 4,
  parameter int CH0_BOOT_BLINK = 1,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_half_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic              tick,
  output logic [N_CH-1:0]   led
);

  localparam int               PRE_DIV   = CLK_HZ / TICK_HZ;
  localparam int               PRE_W     = $clog2(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_TC    = PRE_W'(PRE_DIV - 1);
  localparam logic [PER_W-1:0] BOOT_HALF = PER_W'(clamp_half(32'(TICK_HZ / 4)));

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick_q, tick_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_accept;
  logic [N_CH-1:0]   wr_en;

  always_comb begin
    pre_cnt_d   = (pre_cnt_q == PRE_TC) ? '0 : pre_cnt_q + PRE_W'(1);
    tick_d      = (pre_cnt_q == PRE_TC);
    pwm_cnt_d   = pwm_cnt_q + DUTY_W'(1);
    cfg_ready_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q   <= '0;
      tick_q      <= 1'b0;
      pwm_cnt_q   <= '0;
      cfg_ready_q <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      tick_q      <= tick_d;
      pwm_cnt_q   <= pwm_cnt_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_accept = cfg_valid & cfg_ready_q;
  assign cfg_ready  = cfg_ready_q;
  assign tick       = tick_q;

  // Out-of-range channel numbers match no decode and are silently dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic BOOT = (CH0_BOOT_BLINK != 0) && (i == 0);

    assign wr_en[i] = cfg_accept && (int'(cfg_ch) == i);

    led_blink_chan #(
      .PER_W      (PER_W),
      .DUTY_W     (DUTY_W),
      .BOOT_MODE  (BOOT ? MODE_BLINK : MODE_OFF),
      .BOOT_HALF  (BOOT ? BOOT_HALF : PER_W'(1)),
      .BOOT_PHASE (BOOT)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick_q),
      .pwm_cnt (pwm_cnt_q),
      .wr_en   (wr_en[i]),
      .wr_mode (led_mode_e'(cfg_mode)),
      .wr_half (cfg_half_period),
      .wr_duty (cfg_duty),
      .led     (led[i])
    );
  end

endmodule
